vs1003_bus_responder: RTL
=========================

// Module: vs1003_bus_responder
// PURPOSE
// - Device-side end of the VS1003 serial bus (SCI command + SDI data channels); mirrors the codec for the MP3 player master.
// - Oversamples XCS/XDCS/SCLK/SI on CLK and decodes SCI write/read frames into a 16x16 register file.
// - Buffers SDI bytes in a FIFO drained by a local consumer, and drives DREQ from FIFO free space.
// - Used as synthesizable loopback/emulation target on the board and as the bus model in system sims.
// PARAMETERS
// FIFO_DEPTH   64  SDI byte FIFO entries (power of 2)
// DREQ_FREE    32  DREQ high while free entries >= DREQ_FREE
// SYNC_STAGES  2   flip-flop synchronizer depth on XCS/XDCS/SCLK/SI/RSET
// PORTS
// CLK          in   1   system clock, 100 MHz
// RST          in   1   async active-low reset
// XCS          in   1   SCI chip select, active low
// XDCS         in   1   SDI chip select, active low
// SCLK         in   1   serial clock from master, mode 0 (idle low)
// SI           in   1   serial data from master, MSB first
// RSET         in   1   codec XRESET, active low, soft reset
// SO           out  1   serial read data (0 when not driving a read)
// DREQ         out  1   data request to master
// sci_wr_stb   out  1   1-cycle pulse per completed SCI write
// sci_wr_addr  out  4   address of last SCI write
// sci_wr_data  out  16  data of last SCI write
// sci_mode     out  16  register 0x0 (SCI_MODE)
// sci_vol      out  16  register 0xB (SCI_VOL)
// sdi_rd       in   1   pop one byte from FIFO
// sdi_data     out  8   popped byte, valid when sdi_valid
// sdi_valid    out  1   1-cycle pulse, cycle after accepted sdi_rd
// sdi_empty    out  1   FIFO empty
// sdi_ovf      out  1   sticky: byte arrived while FIFO full
// BEHAVIOUR
// - Reset (RST low, async): SO=0, DREQ=0, sci_wr_stb=0, sci_wr_addr=0, sci_wr_data=0, sdi_valid=0, sdi_empty=1,
//   sdi_ovf=0, regs cleared except reg0=0x0800; FSMs IDLE, FIFO empty. RSET low (synchronized) does the same, synchronously.
// - Sync: inputs pass SYNC_STAGES flops; SCLK rise/fall = edge detect on synced SCLK (1-cycle pulses).
//   Master SCLK high and low phases >= 4 CLK each; faster clocks are unsupported.
// - SI sampled on SCLK rise; SO updated on SCLK fall. SCI has priority: XCS and XDCS both low -> SDI bits ignored.
// - SCI FSM: IDLE -> OPC (8b) -> ADDR (8b) -> DATA (16b) -> DONE (ignore bits until XCS high) -> IDLE.
//   Entered on XCS fall; any XCS rise returns to IDLE from any state, discarding partial frame (no strobe, no reg write).
// - Opcode 0x02 write: on 32nd bit rise, reg[addr[3:0]]<=data; next cycle sci_wr_stb=1 with addr/data, outputs updated same cycle.
//   addr > 0x0F: no write, no strobe. Opcode not 0x02/0x03: DONE after OPC.
// - Opcode 0x03 read: after 8th addr bit rise, load shift reg with reg[addr] (0x0000 if addr>0x0F);
//   MSB on SO at next SCLK fall, one bit per fall, 16 bits; SO=0 after and on XCS rise.
// - SDI: XDCS low and XCS high: 8 rises -> byte pushed 1 cycle after 8th rise. XDCS rise drops partial byte.
//   Bit counter reset on XDCS fall.
// - FIFO: push when full -> byte dropped, sdi_ovf<=1 until reset/RSET. sdi_rd when empty ignored (no sdi_valid).
//   Push and pop same cycle: both happen, count unchanged; pop on full frees one, so concurrent push is accepted.
// - DREQ registered: 1 iff RSET synced high and (FIFO_DEPTH - count) >= DREQ_FREE; updates cycle after count change.
// CONFIGURATION
// - SCI_READ_EN defined: opcode 0x03 supported as above.
// - SCI_READ_EN undefined: 0x03 treated as unknown opcode (DONE), SO tied 0, read shift logic removed.
// TESTING
// - Release RST, RSET=1, bus idle -> DREQ=1 within SYNC_STAGES+2 cycles; sci_mode=0x0800, sci_vol=0, sdi_empty=1.
// - SCI frame 0x02,0x0B,0x2020 -> one sci_wr_stb, sci_wr_addr=0xB, sci_vol=0x2020; other regs unchanged.
// - Same frame, XCS raised after 20 bits -> no sci_wr_stb, sci_vol keeps prior value; next full frame decodes.
// - 33 SDI bytes 0x00..0x20, no pops -> DREQ=1 after byte 32, DREQ=0 after byte 33; pops return 0x00.. in order.
// - 65 bytes, no pops -> sdi_ovf=1 after byte 65; 64 pops return bytes 0..63, then sdi_empty=1, DREQ=1.
// - SCI_READ_EN: frame 0x03,0x00 after reset -> SO shifts 0x0800 MSB first; without macro SO stays 0.

Source files
------------

// File: rtl/vs1003_bus_responder.sv
// vs1003_bus_responder: VS1003 SCI/SDI device-side emulation with register file and SDI byte FIFO.
// Define SCI_READ_EN to support SCI read (opcode 0x03) frames on SO.
module vs1003_bus_responder #(
    parameter int FIFO_DEPTH  = 64,
    parameter int DREQ_FREE   = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        XCS,
    input  logic        XDCS,
    input  logic        SCLK,
    input  logic        SI,
    input  logic        RSET,
    output logic        SO,
    output logic        DREQ,
    output logic        sci_wr_stb,
    output logic [3:0]  sci_wr_addr,
    output logic [15:0] sci_wr_data,
    output logic [15:0] sci_mode,
    output logic [15:0] sci_vol,
    input  logic        sdi_rd,
    output logic [7:0]  sdi_data,
    output logic        sdi_valid,
    output logic        sdi_empty,
    output logic        sdi_ovf
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] DREQ_MAX = (AW+1)'(FIFO_DEPTH - DREQ_FREE);
`ifdef SCI_READ_EN
    localparam bit RD_EN = 1'b1;
`else
    localparam bit RD_EN = 1'b0;
`endif

    typedef enum logic [2:0] {S_IDLE, S_OPC, S_ADDR, S_DATA, S_DONE} state_t;

    // Stage order {RSET, SI, SCLK, XDCS, XCS}; reset to the idle bus levels.
    logic [4:0]  sync_q [SYNC_STAGES];
    logic        rset_s, si_s, sclk_s, xdcs_s, xcs_s;
    logic        sclk_p_q, xcs_p_q, xdcs_p_q;
    logic        srst, rise, fall, xcs_fall, xcs_rise, xdcs_edge;
    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [14:0] sh_q;
    logic [7:0]  op_q, addr_q, byte_in;
    logic [15:0] word_in;
    logic        last, op_ok, wr_go;
    logic [15:0] regs_q [16];
    logic        stb_q;
    logic [3:0]  wr_addr_q;
    logic [15:0] wr_data_q;
    logic        sdi_act, push, pop, push_ok, full;
    logic [2:0]  sb_cnt_q;
    logic [6:0]  sb_sh_q;
    logic [7:0]  push_byte;
    logic [7:0]  mem_q [FIFO_DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [AW:0] fcnt_q;
    logic [7:0]  sdi_data_q;
    logic        sdi_valid_q, ovf_q, dreq_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 5'b10011;
            sclk_p_q <= 1'b0;
            xcs_p_q  <= 1'b1;
            xdcs_p_q <= 1'b1;
        end else begin
            sync_q[0] <= {RSET, SI, SCLK, XDCS, XCS};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            sclk_p_q <= sclk_s;
            xcs_p_q  <= xcs_s;
            xdcs_p_q <= xdcs_s;
        end
    end

    assign {rset_s, si_s, sclk_s, xdcs_s, xcs_s} = sync_q[SYNC_STAGES-1];
    assign srst      = ~rset_s;
    assign rise      = sclk_s & ~sclk_p_q;
    assign fall      = ~sclk_s & sclk_p_q;
    assign xcs_fall  = xcs_p_q & ~xcs_s;
    assign xcs_rise  = ~xcs_p_q & xcs_s;
    assign xdcs_edge = xdcs_p_q ^ xdcs_s;

    assign byte_in = {sh_q[6:0], si_s};
    assign word_in = {sh_q, si_s};
    assign last    = (state_q == S_DATA) ? (cnt_q == 4'd15) : (cnt_q == 4'd7);
    assign op_ok   = (byte_in == 8'h02) || (RD_EN && byte_in == 8'h03);
    assign wr_go   = rise && last && state_q == S_DATA && op_q == 8'h02 && addr_q[7:4] == 4'd0 && !xcs_rise;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (xcs_rise) begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
        end else begin
            unique case (state_q)
                S_IDLE: if (xcs_fall) begin
                    state_d = S_OPC;
                    cnt_d   = 4'd0;
                end
                S_OPC, S_ADDR, S_DATA: if (rise) begin
                    cnt_d = last ? 4'd0 : cnt_q + 4'd1;
                    if (last) state_d = (state_q == S_OPC) ? (op_ok ? S_ADDR : S_DONE) :
                                        (state_q == S_ADDR) ? S_DATA : S_DONE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else if (srst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sh_q <= '0; op_q <= '0; addr_q <= '0; stb_q <= 1'b0; wr_addr_q <= '0; wr_data_q <= '0;
            for (int i = 0; i < 16; i++) regs_q[i] <= (i == 0) ? 16'h0800 : 16'h0000;
        end else if (srst) begin
            sh_q <= '0; op_q <= '0; addr_q <= '0; stb_q <= 1'b0; wr_addr_q <= '0; wr_data_q <= '0;
            for (int i = 0; i < 16; i++) regs_q[i] <= (i == 0) ? 16'h0800 : 16'h0000;
        end else begin
            if (rise && (state_q == S_OPC || state_q == S_ADDR || state_q == S_DATA)) sh_q <= word_in[14:0];
            if (rise && last && state_q == S_OPC) op_q <= byte_in;
            if (rise && last && state_q == S_ADDR) addr_q <= byte_in;
            stb_q <= wr_go;
            if (wr_go) begin
                regs_q[addr_q[3:0]] <= word_in;
                wr_addr_q <= addr_q[3:0];
                wr_data_q <= word_in;
            end
        end
    end

`ifdef SCI_READ_EN
    logic [15:0] rd_sh_q;
    logic [4:0]  rd_cnt_q;
    logic        so_q, rd_load;
    assign rd_load = rise && last && state_q == S_ADDR && op_q == 8'h03;
    // Each SCLK fall presents the next bit; once 16 are out SO returns to 0.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rd_sh_q <= '0; rd_cnt_q <= '0; so_q <= 1'b0;
        end else if (srst || xcs_rise) begin
            rd_sh_q <= '0; rd_cnt_q <= '0; so_q <= 1'b0;
        end else if (rd_load) begin
            rd_sh_q  <= (byte_in[7:4] == 4'd0) ? regs_q[byte_in[3:0]] : 16'h0000;
            rd_cnt_q <= 5'd16;
        end else if (fall) begin
            so_q     <= (rd_cnt_q != 5'd0) && rd_sh_q[15];
            rd_sh_q  <= rd_sh_q << 1;
            rd_cnt_q <= rd_cnt_q - 5'(rd_cnt_q != 5'd0);
        end
    end
    assign SO = so_q;
`else
    assign SO = 1'b0;
`endif

    assign sdi_act   = ~xdcs_s & xcs_s;
    assign push      = rise && sdi_act && sb_cnt_q == 3'd7 && !xdcs_edge;
    assign push_byte = {sb_sh_q, si_s};
    assign full      = fcnt_q == FULL_CNT;
    assign pop       = sdi_rd && fcnt_q != '0;
    assign push_ok   = push && (!full || pop);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sb_cnt_q <= '0; sb_sh_q <= '0;
        end else if (srst || xdcs_edge) begin
            sb_cnt_q <= '0; sb_sh_q <= '0;
        end else if (rise && sdi_act) begin
            sb_cnt_q <= sb_cnt_q + 3'd1;
            sb_sh_q  <= push_byte[6:0];
        end
    end

    always_ff @(posedge CLK) begin
        if (push_ok) mem_q[wp_q] <= push_byte;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wp_q <= '0; rp_q <= '0; fcnt_q <= '0; sdi_data_q <= '0; sdi_valid_q <= 1'b0; ovf_q <= 1'b0; dreq_q <= 1'b0;
        end else if (srst) begin
            wp_q <= '0; rp_q <= '0; fcnt_q <= '0; sdi_data_q <= '0; sdi_valid_q <= 1'b0; ovf_q <= 1'b0; dreq_q <= 1'b0;
        end else begin
            wp_q        <= wp_q + AW'(push_ok);
            rp_q        <= rp_q + AW'(pop);
            fcnt_q      <= fcnt_q + (AW+1)'(push_ok) - (AW+1)'(pop);
            sdi_valid_q <= pop;
            if (pop) sdi_data_q <= mem_q[rp_q];
            if (push && !push_ok) ovf_q <= 1'b1;
            dreq_q      <= fcnt_q <= DREQ_MAX;
        end
    end

    assign DREQ        = dreq_q;
    assign sci_wr_stb  = stb_q;
    assign sci_wr_addr = wr_addr_q;
    assign sci_wr_data = wr_data_q;
    assign sci_mode    = regs_q[0];
    assign sci_vol     = regs_q[11];
    assign sdi_data    = sdi_data_q;
    assign sdi_valid   = sdi_valid_q;
    assign sdi_empty   = fcnt_q == '0;
    assign sdi_ovf     = ovf_q;
endmodule
